cpu_ctrl_fsm: RTL and testbench

//   Multi-cycle control unit for the 16-bit accumulator CPU. Sequences each instruction through

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/cpu_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: opcodes, ALU op codes and
// the control FSM state encoding.
package cpu_pkg;

   localparam int unsigned WAIT_W = 4;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_NOT   = 4'h7;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JZ    = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // 0 is left unused so an idle control word reads as "no ALU operation".
   localparam logic [3:0] ALU_NONE   = 4'h0;
   localparam logic [3:0] ALU_ADD    = 4'h1;
   localparam logic [3:0] ALU_SUB    = 4'h2;
   localparam logic [3:0] ALU_AND    = 4'h3;
   localparam logic [3:0] ALU_OR     = 4'h4;
   localparam logic [3:0] ALU_NOT    = 4'h5;
   localparam logic [3:0] ALU_PASS_B = 4'h6;

   typedef enum logic [3:0] {
      StIdle, StFAddr, StFMem, StFIr, StDecode, StEAddr,
      StEMem, StEAcc, StEStd, StEWr, StEJmp, StHalt
   } state_t;

   function automatic logic [3:0] alu_for_op(input logic [3:0] op);
      logic [3:0] res;
      res = ALU_NONE;
      case (op)
         OP_LOAD: res = ALU_PASS_B;
         OP_ADD:  res = ALU_ADD;
         OP_SUB:  res = ALU_SUB;
         OP_AND:  res = ALU_AND;
         OP_OR:   res = ALU_OR;
         OP_NOT:  res = ALU_NOT;
         default: res = ALU_NONE;
      endcase
      return res;
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'hA) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU. All outputs are
// decoded from the state register and the opcode held in IR.
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [15:0]      ir,
   input  logic             zflag,
   output logic             pc_ld,
   output logic             pc_inc,
   output logic             ir_ld,
   output logic             mar_ld,
   output logic             mar_sel,
   output logic             mdr_ld,
   output logic             mdr_sel,
   output logic             acc_ld,
   output logic             zflag_ld,
   output logic [3:0]       alu_op,
   output logic             mem_rw,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT - 1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              boundary, retire;
   logic [3:0]        opcode;
   logic              unused_ir;

   assign opcode    = ir[15:12];
   assign unused_ir = ^ir[11:0];
   assign instr_cnt = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (retire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      boundary = 1'b0;
      retire   = 1'b0;
      unique case (state_q)
         StIdle:  if (run) state_d = StFAddr;
         StFAddr: begin
            state_d = StFMem;
            wait_d  = WAIT_INIT;
         end
         StFMem: begin
            if (wait_q == '0) state_d = StFIr;
            else wait_d = wait_q - WAIT_W'(1);
         end
         StFIr:   state_d = StDecode;
         StDecode: begin
            case (opcode)
               OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = StEAddr;
               OP_NOT:        state_d = StEAcc;
               OP_JMP, OP_JZ: state_d = StEJmp;
               OP_HALT: begin
                  state_d = StHalt;
                  retire  = 1'b1;
               end
               default:       boundary = 1'b1;
            endcase
         end
         StEAddr: begin
            state_d = (opcode == OP_STORE) ? StEStd : StEMem;
            wait_d  = WAIT_INIT;
         end
         StEMem: begin
            if (wait_q == '0) state_d = StEAcc;
            else wait_d = wait_q - WAIT_W'(1);
         end
         StEAcc:  boundary = 1'b1;
         StEStd: begin
            state_d = StEWr;
            wait_d  = WAIT_INIT;
         end
         StEWr: begin
            if (wait_q == '0) boundary = 1'b1;
            else wait_d = wait_q - WAIT_W'(1);
         end
         StEJmp:  boundary = 1'b1;
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
      if (boundary) begin
         retire  = 1'b1;
         state_d = run ? StFAddr : StIdle;
      end
   end

   always_comb begin
      pc_ld    = 1'b0;
      pc_inc   = 1'b0;
      ir_ld    = 1'b0;
      mar_ld   = 1'b0;
      mar_sel  = 1'b0;
      mdr_ld   = 1'b0;
      mdr_sel  = 1'b0;
      acc_ld   = 1'b0;
      zflag_ld = 1'b0;
      alu_op   = ALU_NONE;
      mem_rw   = 1'b0;
      halted   = 1'b0;
      illegal  = 1'b0;
      unique case (state_q)
         StFAddr:  mar_ld = 1'b1;
         StFMem:   mdr_ld = (wait_q == '0);
         StFIr: begin
            ir_ld  = 1'b1;
            pc_inc = 1'b1;
         end
         StDecode: illegal = is_illegal(opcode);
         StEAddr: begin
            mar_ld  = 1'b1;
            mar_sel = 1'b1;
         end
         StEMem:   mdr_ld = (wait_q == '0);
         StEAcc: begin
            acc_ld   = 1'b1;
            zflag_ld = 1'b1;
            alu_op   = alu_for_op(opcode);
         end
         StEStd: begin
            mdr_ld  = 1'b1;
            mdr_sel = 1'b1;
         end
         StEWr:    mem_rw = 1'b1;
         // JZ takes the branch only when the registered zero flag is set.
         StEJmp:   pc_ld = (opcode == OP_JMP) | zflag;
         StHalt:   halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: two instances (MEM_WAIT 1 and 3) each drive a small datapath
// and RAM; results are checked against an instruction-level model of the CPU.
module tb_cpu_ctrl_fsm;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]       run = '0;
   logic [1:0]       zf;
   logic [1:0][15:0] ir_r;
   logic [1:0]       pc_ld, pc_inc, ir_ld, mar_ld, mar_sel, mdr_ld, mdr_sel;
   logic [1:0]       acc_ld, zflag_ld, mem_rw, halted, illegal;
   logic [1:0][3:0]  alu_op;
   logic [1:0][15:0] instr_cnt;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      cpu_ctrl_fsm #(.MEM_WAIT((g == 0) ? 1 : 3), .CNT_W(16)) u_dut (
         .clk(clk), .rst(rst), .run(run[g]), .ir(ir_r[g]), .zflag(zf[g]),
         .pc_ld(pc_ld[g]), .pc_inc(pc_inc[g]), .ir_ld(ir_ld[g]), .mar_ld(mar_ld[g]),
         .mar_sel(mar_sel[g]), .mdr_ld(mdr_ld[g]), .mdr_sel(mdr_sel[g]), .acc_ld(acc_ld[g]),
         .zflag_ld(zflag_ld[g]), .alu_op(alu_op[g]), .mem_rw(mem_rw[g]), .halted(halted[g]),
         .illegal(illegal[g]), .instr_cnt(instr_cnt[g])
      );
   end

   // Datapath registers and RAM per instance; an image is copied in when ld_en is high.
   logic [7:0]  pc [2];
   logic [7:0]  mar [2];
   logic [15:0] mdr [2];
   logic [15:0] acc [2];
   logic [15:0] mem [2][256];
   logic        ld_en = 1'b0;
   int          ld_k = 0;
   logic [7:0]  img_pc;
   logic [15:0] img_acc;
   logic        img_z;
   logic [15:0] img_mem [256];

   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, b);
      case (op)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_AND:    return a & b;
         ALU_OR:     return a | b;
         ALU_NOT:    return ~a;
         ALU_PASS_B: return b;
         default:    return 16'hxxxx;
      endcase
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ld_en && ld_k == k) begin
            pc[k] <= img_pc; acc[k] <= img_acc; zf[k] <= img_z;
            ir_r[k] <= 16'h0; mar[k] <= 8'h0; mdr[k] <= 16'h0;
            for (int a = 0; a < 256; a++) mem[k][a] <= img_mem[a];
         end else begin
            if (pc_ld[k]) pc[k] <= ir_r[k][7:0];
            else if (pc_inc[k]) pc[k] <= pc[k] + 8'd1;
            if (ir_ld[k]) ir_r[k] <= mdr[k];
            if (mar_ld[k]) mar[k] <= mar_sel[k] ? ir_r[k][7:0] : pc[k];
            if (mdr_ld[k]) mdr[k] <= mdr_sel[k] ? acc[k] : mem[k][mar[k]];
            if (acc_ld[k]) acc[k] <= alu_f(alu_op[k], acc[k], mdr[k]);
            if (zflag_ld[k]) zf[k] <= (alu_f(alu_op[k], acc[k], mdr[k]) == 16'h0);
            if (mem_rw[k]) mem[k][mar[k]] <= mdr[k];
         end
      end
   end

   int n_chk = 0, n_fail = 0;
   int rw_cyc [2], ill_cyc [2], ovl [2];
   int last_cyc;

   // Instruction-level reference model.
   logic [15:0] m_mem [256];
   logic [7:0]  m_pc;
   logic [15:0] m_acc;
   logic        m_z, m_halt;
   int          m_cyc, m_ret, m_st, m_ill;

   task automatic model_run(input int w, input int nmax);
      logic [15:0] ins;
      logic [7:0]  a;
      m_cyc = 0; m_ret = 0; m_st = 0; m_ill = 0; m_halt = 1'b0;
      while (m_ret < nmax && !m_halt) begin
         ins = m_mem[m_pc]; a = ins[7:0];
         m_pc = m_pc + 8'd1;
         m_ret++;
         // Fetch + decode costs 3+w; memory operands add address and w access cycles.
         case (ins[15:12])
            4'h0: m_cyc += 3 + w;
            4'h1: begin m_acc = m_mem[a]; m_z = (m_acc == 0); m_cyc += 5 + 2*w; end
            4'h2: begin m_mem[a] = m_acc; m_st++; m_cyc += 5 + 2*w; end
            4'h3: begin m_acc = m_acc + m_mem[a]; m_z = (m_acc == 0); m_cyc += 5 + 2*w; end
            4'h4: begin m_acc = m_acc - m_mem[a]; m_z = (m_acc == 0); m_cyc += 5 + 2*w; end
            4'h5: begin m_acc = m_acc & m_mem[a]; m_z = (m_acc == 0); m_cyc += 5 + 2*w; end
            4'h6: begin m_acc = m_acc | m_mem[a]; m_z = (m_acc == 0); m_cyc += 5 + 2*w; end
            4'h7: begin m_acc = ~m_acc; m_z = (m_acc == 0); m_cyc += 4 + w; end
            4'h8: begin m_pc = a; m_cyc += 4 + w; end
            4'h9: begin if (m_z) m_pc = a; m_cyc += 4 + w; end
            4'hF: begin m_halt = 1'b1; m_cyc += 3 + w; end
            default: begin m_ill++; m_cyc += 3 + w; end
         endcase
      end
   endtask

   function automatic logic [15:0] outs(input int k);
      return {pc_ld[k], pc_inc[k], ir_ld[k], mar_ld[k], mar_sel[k], mdr_ld[k], mdr_sel[k],
              acc_ld[k], zflag_ld[k], alu_op[k], mem_rw[k], illegal[k], halted[k]};
   endfunction

   task automatic step();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (mem_rw[k]) rw_cyc[k]++;
         if (illegal[k]) ill_cyc[k]++;
         if (pc_ld[k] && pc_inc[k]) ovl[k]++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; run = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_img();
      for (int a = 0; a < 256; a++) img_mem[a] = 16'h0;
      img_pc = 8'h0; img_acc = 16'h0; img_z = 1'b0;
   endtask

   task automatic load_image(input int k);
      ld_k = k; ld_en = 1'b1;
      step();
      ld_en = 1'b0;
   endtask

   task automatic run_prog(input int k, input int nmax, input string tag);
      int w, cyc, bound, mism;
      logic [15:0] start;
      w = (k == 0) ? 1 : 3;
      m_mem = img_mem; m_pc = img_pc; m_acc = img_acc; m_z = img_z;
      model_run(w, nmax);
      load_image(k);
      rw_cyc[k] = 0; ill_cyc[k] = 0; ovl[k] = 0;
      start = instr_cnt[k];
      run[k] = 1'b1; cyc = 0; bound = m_ret * (5 + 2*w) + 10;
      while (int'(16'(instr_cnt[k] - start)) != m_ret && cyc < bound) begin
         step(); cyc++;
         if (int'(16'(instr_cnt[k] - start)) == m_ret - 1) run[k] = 1'b0;
      end
      run[k] = 1'b0;
      last_cyc = cyc;
      n_chk++; if (cyc != m_cyc + 1)
         begin n_fail++; $display("FAIL %s[%0d] cycles: got %0d want %0d", tag, k, cyc, m_cyc + 1); end
      n_chk++; if (acc[k] !== m_acc)
         begin n_fail++; $display("FAIL %s[%0d] acc: got %h want %h", tag, k, acc[k], m_acc); end
      n_chk++; if (zf[k] !== m_z)
         begin n_fail++; $display("FAIL %s[%0d] zflag: got %b want %b", tag, k, zf[k], m_z); end
      n_chk++; if (pc[k] !== m_pc)
         begin n_fail++; $display("FAIL %s[%0d] pc: got %h want %h", tag, k, pc[k], m_pc); end
      mism = 0;
      for (int a = 0; a < 256; a++) if (mem[k][a] !== m_mem[a]) mism++;
      n_chk++; if (mism != 0)
         begin n_fail++; $display("FAIL %s[%0d] ram: got %0d bad words want 0", tag, k, mism); end
      n_chk++; if (rw_cyc[k] != m_st * w) begin
         n_fail++; $display("FAIL %s[%0d] mem_rw cycles: got %0d want %0d", tag, k, rw_cyc[k], m_st*w);
      end
      n_chk++; if (ill_cyc[k] != m_ill) begin
         n_fail++; $display("FAIL %s[%0d] illegal pulses: got %0d want %0d", tag, k, ill_cyc[k], m_ill);
      end
      n_chk++; if (ovl[k] != 0)
         begin n_fail++; $display("FAIL %s[%0d] pc_ld/pc_inc overlap: got %0d want 0", tag, k, ovl[k]); end
      n_chk++; if (outs(k) !== {15'b0, m_halt})
         begin n_fail++; $display("FAIL %s[%0d] end outputs: got %h want %h", tag, k, outs(k), {15'b0, m_halt}); end
   endtask

   task automatic test_reset();
      int bad [2];
      rst = 1'b1; run = '0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_chk++; if (outs(k) !== 16'h0 || instr_cnt[k] !== 16'h0) begin
            n_fail++; $display("FAIL reset[%0d] in reset: got %h/%h want 0/0", k, outs(k), instr_cnt[k]);
         end
      end
      rst = 1'b0; bad[0] = 0; bad[1] = 0;
      repeat (10) begin
         step();
         for (int k = 0; k < 2; k++) if (outs(k) !== 16'h0 || instr_cnt[k] !== 16'h0) bad[k]++;
      end
      for (int k = 0; k < 2; k++) begin
         n_chk++; if (bad[k] != 0)
            begin n_fail++; $display("FAIL idle[%0d]: got %0d bad cycles want 0", k, bad[k]); end
      end
   endtask

   task automatic test_load_add();
      do_reset(); clear_img();
      img_mem[0] = 16'h1010; img_mem[1] = 16'h3011; img_mem[8'h10] = 16'h0005;
      img_mem[8'h11] = 16'h0007;
      run_prog(0, 2, "load_add");
      n_chk++; if (acc[0] !== 16'h000C || zf[0] !== 1'b0 || instr_cnt[0] !== 16'd2 ||
                   last_cyc != 15) begin
         n_fail++; $display("FAIL load_add: got acc=%h z=%b cnt=%0d cyc=%0d want 000C 0 2 15",
                            acc[0], zf[0], instr_cnt[0], last_cyc);
      end
   endtask

   task automatic test_store();
      int cyc;
      for (int k = 0; k < 2; k++) begin
         do_reset(); clear_img();
         img_acc = 16'h00AB; img_pc = 8'h02; img_mem[2] = 16'h2020;
         run_prog(k, 1, "store");
         n_chk++; if (mem[k][8'h20] !== 16'h00AB || rw_cyc[k] != ((k == 0) ? 1 : 3)) begin
            n_fail++; $display("FAIL store[%0d]: got ram=%h rw=%0d want 00AB %0d",
                               k, mem[k][8'h20], rw_cyc[k], (k == 0) ? 1 : 3);
         end
         do_reset(); clear_img();
         img_acc = 16'h5A5A; img_mem[0] = 16'h2030; img_mem[8'h30] = 16'h1111;
         load_image(k);
         run[k] = 1'b1; cyc = 0;
         while (!mem_rw[k] && cyc < 40) begin step(); cyc++; end
         run[k] = 1'b0;
         #2 rst = 1'b1;
         #1;
         n_chk++; if (mem_rw[k] !== 1'b0 || outs(k) !== 16'h0 || cyc >= 40)
            begin n_fail++; $display("FAIL reset_mid_write[%0d]: got rw=%b cyc=%0d want 0", k, mem_rw[k], cyc); end
         repeat (2) @(negedge clk);
         rst = 1'b0;
         repeat (3) step();
         n_chk++; if (mem[k][8'h30] !== 16'h1111)
            begin n_fail++; $display("FAIL partial_write[%0d]: got %h want 1111", k, mem[k][8'h30]); end
      end
   endtask

   task automatic test_jump();
      for (int k = 0; k < 2; k++) begin
         do_reset(); clear_img();
         img_pc = 8'h05; img_z = 1'b1; img_mem[5] = 16'h9040;
         run_prog(k, 1, "jz_taken");
         n_chk++; if (pc[k] !== 8'h40)
            begin n_fail++; $display("FAIL jz_taken[%0d] pc: got %h want 40", k, pc[k]); end
         img_z = 1'b0;
         run_prog(k, 1, "jz_not_taken");
         n_chk++; if (pc[k] !== 8'h06)
            begin n_fail++; $display("FAIL jz_not_taken[%0d] pc: got %h want 06", k, pc[k]); end
         clear_img(); img_pc = 8'hFF; img_mem[8'hFF] = 16'h8000;
         run_prog(k, 1, "jmp_wrap");
         n_chk++; if (pc[k] !== 8'h00)
            begin n_fail++; $display("FAIL jmp_wrap[%0d] pc: got %h want 00", k, pc[k]); end
      end
   endtask

   task automatic test_illegal_halt();
      int drops;
      logic [15:0] cnt0;
      for (int k = 0; k < 2; k++) begin
         do_reset(); clear_img();
         img_acc = 16'h1234; img_mem[0] = 16'hB000; img_mem[1] = 16'h7000;
         run_prog(k, 2, "illegal");
         n_chk++; if (acc[k] !== 16'hEDCB || ill_cyc[k] != 1)
            begin n_fail++; $display("FAIL illegal[%0d]: got acc=%h pulses=%0d want EDCB 1", k, acc[k], ill_cyc[k]); end
         do_reset(); clear_img();
         img_mem[0] = 16'hF000; img_mem[1] = 16'h7000;
         run_prog(k, 1, "halt");
         cnt0 = instr_cnt[k]; drops = 0;
         for (int i = 0; i < 100; i++) begin
            run[k] = 1'($urandom);
            step();
            if (halted[k] !== 1'b1 || instr_cnt[k] !== cnt0) drops++;
         end
         run[k] = 1'b0;
         n_chk++; if (drops != 0 || cnt0 !== 16'd1)
            begin n_fail++; $display("FAIL halt_hold[%0d]: got %0d bad cycles cnt=%0d want 0 1", k, drops, cnt0); end
      end
   endtask

   task automatic test_run_drop();
      int cyc;
      for (int k = 0; k < 2; k++) begin
         do_reset(); clear_img();
         img_mem[0] = 16'h1010; img_mem[1] = 16'h3011; img_mem[8'h10] = 16'h0005;
         img_mem[8'h11] = 16'h0007;
         load_image(k);
         run[k] = 1'b1; cyc = 0;
         while (!(mar_ld[k] && mar_sel[k]) && cyc < 40) begin step(); cyc++; end
         step();
         run[k] = 1'b0;
         while (instr_cnt[k] != 16'd1 && cyc < 80) begin step(); cyc++; end
         repeat (3) step();
         n_chk++; if (outs(k) !== 16'h0 || pc[k] !== 8'h01 || acc[k] !== 16'h0005 ||
                      instr_cnt[k] !== 16'd1) begin
            n_fail++; $display("FAIL run_drop[%0d]: got out=%h pc=%h acc=%h cnt=%0d want 0 01 0005 1",
                               k, outs(k), pc[k], acc[k], instr_cnt[k]);
         end
         run[k] = 1'b1; cyc = 0;
         step(); run[k] = 1'b0;
         while (instr_cnt[k] != 16'd2 && cyc < 40) begin step(); cyc++; end
         step();
         n_chk++; if (acc[k] !== 16'h000C || pc[k] !== 8'h02 || outs(k) !== 16'h0) begin
            n_fail++; $display("FAIL run_resume[%0d]: got acc=%h pc=%h out=%h want 000C 02 0",
                               k, acc[k], pc[k], outs(k));
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int a = 0; a < 256; a++) img_mem[a] = 16'($urandom);
            img_pc = 8'($urandom); img_acc = 16'($urandom); img_z = 1'($urandom);
            run_prog(k, int'($urandom_range(3, 10)), "random");
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_add();
      test_store();
      test_jump();
      test_illegal_halt();
      test_run_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
